// File: rtl/axi_sitcp_pkg.sv
// Shared types and constants for the SiTCP RBCP-to-AXI4-Lite register path.
package axi_sitcp_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [7:0] RD_ERR_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_RESP,
    R_ADDR,
    R_DATA,
    ACK
  } state_t;

  // One-hot byte lane selected by the low address bits.
  function automatic logic [STRB_W-1:0] lane_onehot(input logic [1:0] lane);
    return STRB_W'(1) << lane;
  endfunction

endpackage

// File: rtl/rbcp_timeout_cnt.sv
// Elapsed-cycle counter for one RBCP command; flags once when the limit is reached.
module rbcp_timeout_cnt
  import axi_sitcp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CMP_W = CNT_W + 1;

  logic [CNT_W-1:0] cnt;
  logic             fired;

  // cnt holds the number of cycles elapsed since the clearing edge; expired is high
  // for exactly one cycle, the cycle in which that count equals TIMEOUT_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      fired   <= 1'b0;
      expired <= 1'b0;
    end else if (clr) begin
      cnt     <= CNT_W'(1);
      fired   <= 1'b0;
      expired <= 1'b0;
    end else if (en) begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
      expired <= 1'b0;
      if (!fired && (({1'b0, cnt} + CMP_W'(1)) == CMP_W'(TIMEOUT_CYCLES))) begin
        expired <= 1'b1;
        fired   <= 1'b1;
      end
    end else begin
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/rbcp_axi_master.sv
// RBCP single-byte command to AXI4-Lite single-beat master with lane steering and timeout.
module rbcp_axi_master
  import axi_sitcp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rbcp_act,
  input  logic [ADDR_W-1:0] rbcp_addr,
  input  logic              rbcp_we,
  input  logic [7:0]        rbcp_wd,
  input  logic              rbcp_re,
  output logic              rbcp_ack,
  output logic [7:0]        rbcp_rd,
  output logic              rbcp_err,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [STRB_W-1:0] araddr_res
);

  state_t            state_q, state_d;
  logic              timed_out_q, timed_out_d;
  logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [ADDR_W-1:0] awaddr_d, araddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic [STRB_W-1:0] wstrb_d, res_d;
  logic              ack_d, err_d;
  logic [7:0]        rd_d;
  logic              cnt_clr, expired, waiting;
  logic              xfer_done, xfer_err;
  logic [7:0]        xfer_rd;

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign waiting = (state_q == W_ADDR) || (state_q == W_RESP) ||
                   (state_q == R_ADDR) || (state_q == R_DATA);

  rbcp_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (waiting),
    .expired(expired)
  );

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    state_d     = state_q;
    timed_out_d = timed_out_q;
    awvalid_d   = m_axi_awvalid;
    wvalid_d    = m_axi_wvalid;
    arvalid_d   = m_axi_arvalid;
    bready_d    = 1'b0;
    rready_d    = 1'b0;
    awaddr_d    = m_axi_awaddr;
    araddr_d    = m_axi_araddr;
    wdata_d     = m_axi_wdata;
    wstrb_d     = m_axi_wstrb;
    res_d       = araddr_res;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rd_d        = rbcp_rd;
    cnt_clr     = 1'b0;
    xfer_done   = 1'b0;
    xfer_err    = 1'b0;
    xfer_rd     = 8'h00;

    case (state_q)
      IDLE: begin
        if (rbcp_act && rbcp_we) begin
          // A read strobe in the same cycle is dropped and reported with an error pulse.
          awaddr_d    = rbcp_addr;
          wdata_d     = {4{rbcp_wd}};
          wstrb_d     = lane_onehot(rbcp_addr[1:0]);
          awvalid_d   = 1'b1;
          wvalid_d    = 1'b1;
          err_d       = rbcp_re;
          cnt_clr     = 1'b1;
          timed_out_d = 1'b0;
          state_d     = W_ADDR;
        end else if (rbcp_act && rbcp_re) begin
          araddr_d    = rbcp_addr;
          res_d       = lane_onehot(rbcp_addr[1:0]);
          arvalid_d   = 1'b1;
          cnt_clr     = 1'b1;
          timed_out_d = 1'b0;
          state_d     = R_ADDR;
        end
      end
      W_ADDR: begin
        if (m_axi_awvalid && m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wvalid && m_axi_wready) wvalid_d = 1'b0;
        if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
          bready_d = 1'b1;
          state_d  = W_RESP;
        end
      end
      W_RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          xfer_done = 1'b1;
          xfer_err  = (m_axi_bresp != RESP_OKAY);
        end else begin
          bready_d = 1'b1;
        end
      end
      R_ADDR: begin
        if (m_axi_arvalid && m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (m_axi_rvalid && m_axi_rready) begin
          xfer_done = 1'b1;
          res_d     = '0;
          if (m_axi_rresp == RESP_OKAY) begin
            xfer_rd = m_axi_rdata[{m_axi_araddr[1:0], 3'b000} +: 8];
          end else begin
            xfer_rd  = RD_ERR_BYTE;
            xfer_err = 1'b1;
          end
        end else begin
          rready_d = 1'b1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Completion acks the host unless the timeout already did; timeout acks early with an error.
    if (xfer_done) begin
      if (timed_out_q) begin
        state_d = IDLE;
      end else begin
        state_d = ACK;
        ack_d   = rbcp_act;
        err_d   = rbcp_act && xfer_err;
        rd_d    = xfer_rd;
      end
    end else if (waiting && expired && !timed_out_q) begin
      timed_out_d = 1'b1;
      ack_d       = rbcp_act;
      err_d       = rbcp_act;
      rd_d        = RD_ERR_BYTE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timed_out_q   <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_araddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      araddr_res    <= '0;
      rbcp_ack      <= 1'b0;
      rbcp_err      <= 1'b0;
      rbcp_rd       <= 8'h00;
    end else begin
      state_q       <= state_d;
      timed_out_q   <= timed_out_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      m_axi_awaddr  <= awaddr_d;
      m_axi_araddr  <= araddr_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      araddr_res    <= res_d;
      rbcp_ack      <= ack_d;
      rbcp_err      <= err_d;
      rbcp_rd       <= rd_d;
    end
  end

endmodule

// File: tb/tb_rbcp_axi_master.sv
// Bench for rbcp_axi_master: table of single transactions plus multi-cycle corner sequences.
module tb_rbcp_axi_master;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rbcp_act, rbcp_we, rbcp_re;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd;
  logic        rbcp_ack, rbcp_err;
  logic [7:0]  rbcp_rd;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb, araddr_res;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  rbcp_axi_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rbcp_act(rbcp_act), .rbcp_addr(rbcp_addr),
    .rbcp_we(rbcp_we), .rbcp_wd(rbcp_wd), .rbcp_re(rbcp_re),
    .rbcp_ack(rbcp_ack), .rbcp_rd(rbcp_rd), .rbcp_err(rbcp_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .araddr_res(araddr_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         ack;
    bit         err;
    logic [7:0] rd;
  } ev_t;

  typedef struct {
    bit          we;
    bit          re;
    logic [31:0] addr;
    logic [7:0]  wd;
    int          aw_c, w_c, b_c, ar_c, r_c;
    logic [31:0] rdata;
    logic [1:0]  bresp, rresp;
    int          ncyc, rst_c, act_lo_from, act_lo_to, extra_re_c;
  } cfg_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    logic [3:0]  exp_res;
    logic [7:0]  exp_rd;
    bit          exp_err;
  } vec_t;

  ev_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   tr_aw[64], tr_w[64], tr_b[64], tr_ar[64], tr_r[64];
  logic [3:0]  tr_res[64];
  logic [31:0] snap_awaddr, snap_wdata, snap_araddr;
  logic [3:0]  snap_wstrb;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                 rbcp_ack, rbcp_err, rbcp_rd, araddr_res, m_axi_awaddr, m_axi_wdata,
                 m_axi_wstrb, m_axi_araddr, m_axi_awprot, m_axi_arprot});
  endfunction

  function automatic cfg_t base_cfg();
    cfg_t c;
    c.we = 1'b0; c.re = 1'b0; c.addr = '0; c.wd = '0;
    c.aw_c = -1; c.w_c = -1; c.b_c = -1; c.ar_c = -1; c.r_c = -1;
    c.rdata = '0; c.bresp = 2'b00; c.rresp = 2'b00;
    c.ncyc = 5; c.rst_c = -1; c.act_lo_from = -1; c.act_lo_to = -2; c.extra_re_c = -1;
    return c;
  endfunction

  task automatic push_ev(input int cyc, input bit ack, input bit err, input logic [7:0] rd);
    ev_t e;
    e.cyc = cyc; e.ack = ack; e.err = err; e.rd = rd;
    sb.push_back(e);
  endtask

  // Drives one command at cycle 0, plays a scripted slave, traces outputs, scores ack/err events.
  task automatic run_txn(input cfg_t c);
    ev_t e;
    for (int i = 0; i < 64; i++) begin
      tr_aw[i] = 1'b0; tr_w[i] = 1'b0; tr_b[i] = 1'b0; tr_ar[i] = 1'b0; tr_r[i] = 1'b0;
      tr_res[i] = 4'h0;
    end
    for (int k = 0; k <= c.ncyc; k++) begin
      @(negedge clk);
      tr_aw[k] = m_axi_awvalid; tr_w[k] = m_axi_wvalid; tr_b[k] = m_axi_bready;
      tr_ar[k] = m_axi_arvalid; tr_r[k] = m_axi_rready; tr_res[k] = araddr_res;
      if (k == 1) begin
        snap_awaddr = m_axi_awaddr; snap_wdata = m_axi_wdata;
        snap_wstrb = m_axi_wstrb; snap_araddr = m_axi_araddr;
      end
      if (rbcp_ack || rbcp_err) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_event: ack=%0b err=%0b rd=%02h at cycle %0d, expected none",
                   rbcp_ack, rbcp_err, rbcp_rd, k);
        end else begin
          e = sb.pop_front();
          check("ack_event {cycle,ack,err,rd}",
                128'({k, rbcp_ack, rbcp_err, rbcp_rd & {8{rbcp_ack}}}),
                128'({e.cyc, e.ack, e.err, e.rd & {8{e.ack}}}));
        end
      end
      rbcp_we       = (k == 0) && c.we;
      rbcp_re       = ((k == 0) && c.re) || (k == c.extra_re_c);
      rbcp_addr     = c.addr;
      rbcp_wd       = c.wd;
      rbcp_act      = !((k >= c.act_lo_from) && (k <= c.act_lo_to));
      m_axi_awready = (k == c.aw_c);
      m_axi_wready  = (k == c.w_c);
      m_axi_bvalid  = (k == c.b_c);
      m_axi_bresp   = c.bresp;
      m_axi_arready = (k == c.ar_c);
      m_axi_rvalid  = (k == c.r_c);
      m_axi_rdata   = c.rdata;
      m_axi_rresp   = c.rresp;
      if (k == c.rst_c + 1) rst = 1'b0;
      if (k == c.rst_c) begin
        rst = 1'b1;
        #1;
        check("async_reset_clears_outputs", all_outs(), 128'(0));
      end
    end
    rbcp_we = 1'b0; rbcp_re = 1'b0; rbcp_act = 1'b1;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missing_event: no ack/err seen, expected ack=%0b err=%0b at cycle %0d",
               e.ack, e.err, e.cyc);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    cfg_t c;
    logic [3:0] ar_any;

    rst = 1'b1; rbcp_act = 1'b1; rbcp_we = 1'b0; rbcp_re = 1'b0;
    rbcp_addr = '0; rbcp_wd = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_state", all_outs(), 128'(0));
    rst = 1'b0;

    //            wr    addr          wd     rdata         resp   wdata         strb     res      rd     err
    vecs[0] = '{1'b1, 32'h0000_1002, 8'hA5, 32'h0,        2'b00, 32'hA5A5_A5A5, 4'b0100, 4'b0000, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_2003, 8'h00, 32'h1122_3344, 2'b00, 32'h0,        4'b0000, 4'b1000, 8'h11, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_2000, 8'h00, 32'h1122_3344, 2'b00, 32'h0,        4'b0000, 4'b0001, 8'h44, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_2001, 8'h00, 32'h1122_3344, 2'b00, 32'h0,        4'b0000, 4'b0010, 8'h33, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_3000, 8'h3C, 32'h0,        2'b00, 32'h3C3C_3C3C, 4'b0001, 4'b0000, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_3001, 8'hC3, 32'h0,        2'b11, 32'hC3C3_C3C3, 4'b0010, 4'b0000, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_4002, 8'h00, 32'hDEAD_BEEF, 2'b10, 32'h0,        4'b0000, 4'b0100, 8'hFF, 1'b1};
    vecs[7] = '{1'b1, 32'h8000_3003, 8'h5A, 32'h0,        2'b00, 32'h5A5A_5A5A, 4'b1000, 4'b0000, 8'h00, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FFFE, 8'h00, 32'hCAFE_F00D, 2'b00, 32'h0,        4'b0000, 4'b0100, 8'hFE, 1'b0};
    vecs[9] = '{1'b0, 32'h0000_0001, 8'h00, 32'h5555_5555, 2'b01, 32'h0,        4'b0000, 4'b0010, 8'hFF, 1'b1};

    // Zero-wait slave: ready in cycle 1, response in cycle 2, ack expected in cycle 3.
    for (int i = 0; i < 10; i++) begin
      c = base_cfg();
      c.addr = vecs[i].addr; c.wd = vecs[i].wd; c.rdata = vecs[i].rdata;
      if (vecs[i].wr) begin
        c.we = 1'b1; c.aw_c = 1; c.w_c = 1; c.b_c = 2; c.bresp = vecs[i].resp;
      end else begin
        c.re = 1'b1; c.ar_c = 1; c.r_c = 2; c.rresp = vecs[i].resp;
      end
      push_ev(3, 1'b1, vecs[i].exp_err, vecs[i].exp_rd);
      run_txn(c);
      if (vecs[i].wr) begin
        check($sformatf("v%0d_valids_c1", i), 128'({tr_aw[1], tr_w[1], tr_ar[1]}), 128'(3'b110));
        check($sformatf("v%0d_awaddr", i), 128'(snap_awaddr), 128'(vecs[i].addr));
        check($sformatf("v%0d_wdata", i), 128'(snap_wdata), 128'(vecs[i].exp_wdata));
        check($sformatf("v%0d_wstrb", i), 128'(snap_wstrb), 128'(vecs[i].exp_strb));
        check($sformatf("v%0d_bready_c2", i), 128'({tr_b[1], tr_b[2], tr_b[3]}), 128'(3'b010));
      end else begin
        check($sformatf("v%0d_valids_c1", i), 128'({tr_aw[1], tr_w[1], tr_ar[1]}), 128'(3'b001));
        check($sformatf("v%0d_araddr", i), 128'(snap_araddr), 128'(vecs[i].addr));
        check($sformatf("v%0d_araddr_res_c1", i), 128'(tr_res[1]), 128'(vecs[i].exp_res));
        check($sformatf("v%0d_araddr_res_c3", i), 128'(tr_res[3]), 128'(0));
        check($sformatf("v%0d_rready_c2", i), 128'({tr_r[1], tr_r[2], tr_r[3]}), 128'(3'b010));
      end
    end

    // Skewed write handshakes with a stray read strobe while busy.
    c = base_cfg();
    c.we = 1'b1; c.addr = 32'h0000_8002; c.wd = 8'h11;
    c.aw_c = 4; c.w_c = 1; c.b_c = 7; c.extra_re_c = 3; c.ncyc = 12;
    push_ev(8, 1'b1, 1'b0, 8'h00);
    run_txn(c);
    check("skew_wvalid_c1_c2", 128'({tr_w[1], tr_w[2]}), 128'(2'b10));
    check("skew_awvalid_c4_c5", 128'({tr_aw[4], tr_aw[5]}), 128'(2'b10));
    check("skew_bready_c4_c5_c7_c8", 128'({tr_b[4], tr_b[5], tr_b[7], tr_b[8]}), 128'(4'b0110));
    ar_any = 4'({tr_ar[3], tr_ar[4], tr_ar[5], tr_ar[6]});
    check("skew_stray_read_ignored", 128'(ar_any), 128'(0));

    // Silent slave: timeout ack at cycle 17, late R handshake then closes quietly.
    c = base_cfg();
    c.re = 1'b1; c.addr = 32'h0000_7001; c.ar_c = 21; c.r_c = 22; c.ncyc = 26;
    c.rdata = 32'h0BAD_F00D;
    push_ev(TO + 1, 1'b1, 1'b1, 8'hFF);
    run_txn(c);
    check("timeout_arvalid_held", 128'({tr_ar[17], tr_ar[20], tr_ar[21], tr_ar[22]}), 128'(4'b1110));
    check("timeout_rready_c22_c23", 128'({tr_r[22], tr_r[23]}), 128'(2'b10));
    check("timeout_araddr_res", 128'({tr_res[20], tr_res[23]}), 128'({4'b0010, 4'b0000}));

    c = base_cfg();
    c.re = 1'b1; c.addr = 32'h0000_7003; c.ar_c = 1; c.r_c = 2; c.rdata = 32'hA1B2_C3D4;
    push_ev(3, 1'b1, 1'b0, 8'hA1);
    run_txn(c);

    // Simultaneous write and read strobes.
    c = base_cfg();
    c.we = 1'b1; c.re = 1'b1; c.addr = 32'h0000_5001; c.wd = 8'h77;
    c.aw_c = 1; c.w_c = 1; c.b_c = 2;
    push_ev(1, 1'b0, 1'b1, 8'h00);
    push_ev(3, 1'b1, 1'b0, 8'h00);
    run_txn(c);
    check("both_no_read", 128'({tr_ar[1], tr_ar[2], tr_ar[3], tr_ar[4], tr_ar[5]}), 128'(0));
    check("both_write_lane", 128'({snap_wdata, snap_wstrb}), 128'({32'h7777_7777, 4'b0010}));

    // Reset in cycle 2 of a read abandons it without an ack.
    c = base_cfg();
    c.re = 1'b1; c.addr = 32'h0000_6003; c.ar_c = 1; c.rst_c = 2; c.ncyc = 8;
    run_txn(c);
    check("rst_read_before", 128'({tr_res[2], tr_r[2]}), 128'({4'b1000, 1'b1}));
    check("rst_read_after", 128'({tr_res[4], tr_r[4], tr_ar[4]}), 128'(0));

    c = base_cfg();
    c.we = 1'b1; c.addr = 32'h0000_6000; c.wd = 8'h99; c.aw_c = 1; c.w_c = 1; c.b_c = 2;
    push_ev(3, 1'b1, 1'b0, 8'h00);
    run_txn(c);

    // Host drops rbcp_act around completion: no ack/err, FSM still returns to IDLE.
    c = base_cfg();
    c.we = 1'b1; c.addr = 32'h0000_9000; c.wd = 8'h12; c.aw_c = 1; c.w_c = 1; c.b_c = 2;
    c.act_lo_from = 2; c.act_lo_to = 3;
    run_txn(c);

    c = base_cfg();
    c.re = 1'b1; c.addr = 32'h0000_9002; c.ar_c = 1; c.r_c = 2; c.rdata = 32'h00EE_0000;
    push_ev(3, 1'b1, 1'b0, 8'hEE);
    run_txn(c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rbcp_axi_master.md
# rbcp_axi_master

Front end of the SiTCP register path. Accepts single-byte RBCP write/read commands from the SiTCP core and issues one AXI4-Lite transaction per command on a 32-bit master port, which feeds `adapter_8_32` directly. Handles lane steering, AXI handshakes, response/timeout errors and the one-cycle RBCP acknowledge.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles after command acceptance before the host is acked with an error; 2..65535.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `rbcp_act` in 1: RBCP transaction active.
- `rbcp_addr` in 32: byte address, sampled on `rbcp_we`/`rbcp_re`.
- `rbcp_we` in 1: write strobe, 1-cycle pulse.
- `rbcp_wd` in 8: write byte, sampled with `rbcp_we`.
- `rbcp_re` in 1: read strobe, 1-cycle pulse.
- `rbcp_ack` out 1: 1-cycle acknowledge.
- `rbcp_rd` out 8: read byte, valid with `rbcp_ack`.
- `rbcp_err` out 1: 1-cycle error pulse.
- `m_axi_aw*`, `m_axi_w*`, `m_axi_b*`, `m_axi_ar*`, `m_axi_r*`: AXI4-Lite master, same signal set and widths as `adapter_8_32` S port (addr 32, data 32, strb 4, prot 3, resp 2).
- `araddr_res` out 4: one-hot read byte lane, to `adapter_8_32`.

## Operation
- FSM states: IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, ACK.
- IDLE, `rbcp_act & rbcp_we`: latch addr/data. Go to W_ADDR. `awvalid`=`wvalid`=1, `awaddr`=`rbcp_addr` unmodified, `wdata`={4{`rbcp_wd`}}, `wstrb`=4'b0001<<addr[1:0], `awprot`=0.
- W_ADDR: each valid drops independently on its own handshake. When both are done, go to W_RESP. `bready`=1 only in W_RESP.
- W_RESP: on the `bvalid` handshake, go to ACK. If `bresp`≠OKAY, set the error flag.
- IDLE, `rbcp_act & rbcp_re`: `arvalid`=1, `araddr`=`rbcp_addr`, `arprot`=0. `araddr_res`=4'b0001<<addr[1:0]. Go to R_ADDR.
- R_ADDR: on the AR handshake, go to R_DATA. `rready`=1 only in R_DATA.
- R_DATA: on the `rvalid` handshake, capture `rd`=`rdata[8*addr[1:0] +: 8]`. If `rresp`≠OKAY, `rd`=8'hFF and set the error flag. Go to ACK.
- `araddr_res` is held from acceptance until the R handshake completes.
- ACK: `rbcp_ack`=1 for exactly one cycle. `rbcp_err`=error flag in the same cycle. Return to IDLE. `rbcp_rd`=0x00 on writes.
- `we` and `re` together in IDLE: the write is performed, the read is dropped, and `rbcp_err` pulses in the next cycle.
- Strobes arriving outside IDLE: ignored.
- `rbcp_act` low at the ACK cycle: the AXI transaction still completes; ack and err are suppressed.
- Timeout:
  - The counter starts at acceptance.
  - If it reaches `TIMEOUT_CYCLES` before the B/R handshake, the block pulses `rbcp_ack` with `rd`=8'hFF and pulses `rbcp_err`.
  - The FSM keeps waiting for AXI completion; valids are never withdrawn before their handshake.
  - Completion then returns to IDLE with no second ack.

## Timing
- All outputs are registered. Reset values: all valids 0, readies 0, `rbcp_ack`/`rbcp_err` 0, `rbcp_rd` 0, `araddr_res` 0, addr/data/strb 0, FSM in IDLE.
- Strobe at cycle 0 → valids high at cycle 1.
- With zero-wait slaves (ready at 1, response at 2), `rbcp_ack` is at cycle 3 for both reads and writes.
- `rst` asserted mid-transaction: immediate return to reset values. No ack is issued, and the AXI handshake in progress is abandoned.

## Structure
- `axi_sitcp_pkg` holds:
  - the state encoding;
  - the `RESP_OKAY`=2'b00 constant;
  - the `RD_ERR_BYTE`=8'hFF constant;
  - the lane one-hot function.
- One sub-module, `rbcp_timeout_cnt`: a 16-bit counter with clear/enable and a one-shot `expired` output compared against `TIMEOUT_CYCLES`.

## Test plan
- Write: addr 0x0000_1002, wd 0xA5, zero-wait slave → wdata 0xA5A5A5A5, wstrb 4'b0100, awaddr 0x0000_1002, ack at cycle 3, err 0.
- Read: addr 0x0000_2003, slave returns rdata 0x1122_3344 OKAY → araddr_res 4'b1000, rd 0x11, ack at cycle 3.
- Skewed handshakes: awready at cycle 4, wready at cycle 1, bvalid at cycle 7 → wvalid drops after cycle 1, awvalid after cycle 4, single ack at cycle 8.
- Read error: rresp 2'b10 → rd 0xFF with ack and err in the same cycle. Write with bresp 2'b11 → ack and err together.
- Timeout: TIMEOUT_CYCLES=16, slave silent → ack, rd 0xFF and err at cycle 17. `arvalid` stays high. A late R handshake returns the FSM to IDLE with no further ack.
- Simultaneous `we`/`re`, and `rst` pulsed at cycle 2 of a read → write-only transaction plus err pulse; reset returns all outputs to 0 immediately, with no ack.
